// File: rtl/multicycle_alu.sv
// Handshaked RISC-V ALU: one-cycle ALU/compare/JALR ops, iterative shift-add MUL/MULHU and
// restoring DIVU/REMU (divider only when ALU_DIV_EN is defined; otherwise those opcodes are illegal).
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Err
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_SLT   = 5'b00011;
  localparam logic [4:0] OP_SLTU  = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_BEQ   = 5'b01010;
  localparam logic [4:0] OP_BNE   = 5'b01011;
  localparam logic [4:0] OP_BLT   = 5'b01100;
  localparam logic [4:0] OP_BGE   = 5'b01101;
  localparam logic [4:0] OP_BLTU  = 5'b01110;
  localparam logic [4:0] OP_BGEU  = 5'b01111;
  localparam logic [4:0] OP_JALR  = 5'b10000;
  localparam logic [4:0] OP_MUL   = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10010;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_REMU  = 5'b10100;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             is_mul, is_div;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero, illegal;
  logic [WIDTH:0]   mul_sum;
  logic [SHW-1:0]   shamt;

  assign is_mul    = (op_q == OP_MUL) || (op_q == OP_MULHU);
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);
`else
  assign is_div    = 1'b0;
`endif
  assign shamt     = b_q[SHW-1:0];
  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = out_valid_q;
  assign Out       = out_q;
  assign Zero      = zero_q;
  assign Err       = err_q;

  // lo_q holds operand A; it doubles as the multiplier/dividend shift register.
  always_comb begin
    alu_out  = '0;
    alu_zero = 1'b0;
    illegal  = 1'b0;
    case (op_q)
      OP_ADD:   alu_out = lo_q + b_q;
      OP_SUB:   alu_out = lo_q - b_q;
      OP_SLL:   alu_out = lo_q << shamt;
      OP_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(lo_q) < $signed(b_q))};
      OP_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (lo_q < b_q)};
      OP_XOR:   alu_out = lo_q ^ b_q;
      OP_SRL:   alu_out = lo_q >> shamt;
      OP_SRA:   alu_out = $signed(lo_q) >>> shamt;
      OP_OR:    alu_out = lo_q | b_q;
      OP_AND:   alu_out = lo_q & b_q;
      OP_BEQ:   alu_zero = (lo_q == b_q);
      OP_BNE:   alu_zero = (lo_q != b_q);
      OP_BLT:   alu_zero = ($signed(lo_q) < $signed(b_q));
      OP_BGE:   alu_zero = ($signed(lo_q) >= $signed(b_q));
      OP_BLTU:  alu_zero = (lo_q < b_q);
      OP_BGEU:  alu_zero = (lo_q >= b_q);
      OP_JALR: begin
        alu_out    = lo_q + b_q;
        alu_out[0] = 1'b0;
      end
      OP_MUL, OP_MULHU: begin
      end
`ifdef ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
      end
`endif
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    err_d       = err_q;
    mul_sum     = '0;
`ifdef ALU_DIV_EN
    div_shift   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          op_d    = OP;
          lo_d    = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = SHW'(WIDTH - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_mul || is_div) begin
          if (is_mul) begin
            mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            acc_d   = mul_sum[WIDTH:1];
            lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
`ifdef ALU_DIV_EN
          else begin
            div_shift = {acc_q, lo_q[WIDTH-1]};
            if (div_shift >= {1'b0, b_q}) begin
              acc_d = div_shift[WIDTH-1:0] - b_q;
              lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_shift[WIDTH-1:0];
              lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end
          end
`endif
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Odd opcodes (mul, divu) take the low/quotient half; even ones the high/remainder.
            out_d       = op_q[0] ? lo_d : acc_d;
            zero_d      = 1'b0;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = DONE;
          end
        end else begin
          out_d       = alu_out;
          zero_d      = alu_zero;
          err_d       = illegal;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      op_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

endmodule
